// File: rtl/io_port_pkg.sv
// Shared encodings and helpers for the memory-mapped output-port bank and its PWM bank.
package io_port_pkg;

  localparam logic [1:0] MODE_WRITE  = 2'd0;
  localparam logic [1:0] MODE_SET    = 2'd1;
  localparam logic [1:0] MODE_CLEAR  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  localparam logic BANK_PORT = 1'b0;
  localparam logic BANK_PWM  = 1'b1;

  // Bytes decoded by one window: two banks of four modes of 2^idx_w registers.
  function automatic int window_size(input int idx_w);
    return 1 << (idx_w + 3);
  endfunction

  function automatic logic [7:0] apply_mode(input logic [1:0] mode,
                                            input logic [7:0] cur,
                                            input logic [7:0] d);
    case (mode)
      MODE_WRITE:  return d;
      MODE_SET:    return cur | d;
      MODE_CLEAR:  return cur & ~d;
      MODE_TOGGLE: return cur ^ d;
      default:     return cur;
    endcase
  endfunction

endpackage

// File: rtl/io_pwm.sv
// Per-channel 8-bit PWM: prescaler, shared phase counter, duty registers and
// registered comparators. Only instantiated when IO_PWM_EN is defined.
module io_pwm
  import io_port_pkg::*;
#(
  parameter int NUM_PWM   = 3,
  parameter int IDX_W     = 2,
  parameter int PWM_DIV_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   idx,
  input  logic [7:0]         wr_data,
  output logic [7:0]         rd_data,
  output logic [NUM_PWM-1:0] pwm_out
);

  logic                    w_tick;
  logic [7:0]              r_phase;
  logic [NUM_PWM-1:0][7:0] w_duty;
  logic [NUM_PWM-1:0]      r_pwm;

  genvar gi;

  if (PWM_DIV_W == 0) begin : g_nodiv
    assign w_tick = 1'b1;
  end else begin : g_div
    logic [PWM_DIV_W-1:0] r_presc;
    always_ff @(posedge clk) begin
      if (reset) r_presc <= '0;
      else       r_presc <= r_presc + 1'b1;
    end
    assign w_tick = &r_presc;
  end

  always_ff @(posedge clk) begin
    if (reset)       r_phase <= 8'h00;
    else if (w_tick) r_phase <= r_phase + 8'h01;
  end

  for (gi = 0; gi < NUM_PWM; gi++) begin : g_duty
    logic [7:0] r_duty;
    always_ff @(posedge clk) begin
      if (reset)                                 r_duty <= 8'h00;
      else if (wr_en && idx == IDX_W'(gi))       r_duty <= wr_data;
    end
    assign w_duty[gi] = r_duty;
  end

  // Compare against the current phase; output therefore lags phase by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_PWM; i++) r_pwm[i] <= w_duty[i] > r_phase;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_PWM; i++) begin
      if (idx == IDX_W'(i)) rd_data = w_duty[i];
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: rtl/io_port_bank.sv
// Bank of read-back 8-bit output ports with set/clear/toggle write modes and a
// registered one-cycle read path; the PWM bank is built only with IO_PWM_EN.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0400,
  parameter int          IDX_W       = 2,
  parameter int          NUM_PORTS   = 4,
  parameter int          NUM_PWM     = 3,
  parameter int          PWM_DIV_W   = 4,
  parameter logic [7:0]  RESET_VALUE = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            addr,
  input  logic [7:0]             data_in,
  input  logic                   write_enable,
  output logic [7:0]             data_out,
  output logic                   sel,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [NUM_PWM-1:0]     pwm_out
);

  localparam logic [15:0] WIN_MASK = ~(16'(window_size(IDX_W)) - 16'd1);

  logic             w_hit;
  logic             w_bank;
  logic [1:0]       w_mode;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_rd_data;
  logic [7:0]       w_pwm_rd;
  logic [7:0]       r_data_out;
  logic             r_sel;

  genvar gi;

  assign w_hit  = (addr & WIN_MASK) == (BASE_ADDR & WIN_MASK);
  assign w_bank = addr[IDX_W+2];
  assign w_mode = addr[IDX_W+1:IDX_W];
  assign w_idx  = addr[IDX_W-1:0];

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [7:0] r_port;
    always_ff @(posedge clk) begin
      if (reset)
        r_port <= RESET_VALUE;
      else if (write_enable && w_hit && w_bank == BANK_PORT && w_idx == IDX_W'(gi))
        r_port <= apply_mode(w_mode, r_port, data_in);
    end
    assign port_out[8*gi +: 8] = r_port;
  end

`ifdef IO_PWM_EN
  io_pwm #(
    .NUM_PWM   (NUM_PWM),
    .IDX_W     (IDX_W),
    .PWM_DIV_W (PWM_DIV_W)
  ) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (write_enable && w_hit && w_bank == BANK_PWM),
    .idx     (w_idx),
    .wr_data (data_in),
    .rd_data (w_pwm_rd),
    .pwm_out (pwm_out)
  );
`else
  assign w_pwm_rd = 8'h00;
  assign pwm_out  = '0;
  // PWM_DIV_W has no effect in this build.
  if (PWM_DIV_W < 0) begin : g_div_unused
  end
`endif

  always_comb begin
    w_rd_data = 8'h00;
    if (w_bank == BANK_PWM) begin
      w_rd_data = w_pwm_rd;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_idx == IDX_W'(i)) w_rd_data = port_out[8*i +: 8];
      end
    end
  end

  // Read path samples pre-write state and is forced to zero whenever sel drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= 8'h00;
      r_sel      <= 1'b0;
    end else begin
      r_sel      <= w_hit && !write_enable;
      r_data_out <= (w_hit && !write_enable) ? w_rd_data : 8'h00;
    end
  end

  assign data_out = r_data_out;
  assign sel      = r_sel;

endmodule
